// File: rtl/gf64_pkg.sv
// GF(2^6) arithmetic (polynomial basis, P(z) = z^6 + z + 1) and shared types
// for the power-map engine.
package gf64_pkg;

  localparam int unsigned GF_W    = 6;
  localparam logic [6:0]  GF_POLY = 7'h43;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // LSB position of a lane inside a packed multi-lane word.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * GF_W;
  endfunction

  // Shift-and-add product, reducing by P after every shift.
  function automatic logic [GF_W-1:0] gf64_mul(input logic [GF_W-1:0] a,
                                               input logic [GF_W-1:0] b);
    logic [GF_W-1:0] p;
    logic [GF_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[GF_W-1] ? ({aa[GF_W-2:0], 1'b0} ^ GF_POLY[GF_W-1:0])
                      : {aa[GF_W-2:0], 1'b0};
    end
    return p;
  endfunction

  // Squaring is linear: z^6 = z+1, z^8 = z^3+z^2, z^10 = z^5+z^4.
  function automatic logic [GF_W-1:0] gf64_sq(input logic [GF_W-1:0] a);
    return {a[5], a[2] ^ a[5], a[4], a[1] ^ a[4], a[3], a[0] ^ a[3]};
  endfunction

endpackage

// File: rtl/gf64_lane_step.sv
// One square-and-multiply step for a single lane:
// next = bit ? sq(acc) * base : sq(acc).
module gf64_lane_step
  import gf64_pkg::*;
(
  input  logic [GF_W-1:0] i_acc,
  input  logic [GF_W-1:0] i_base,
  input  logic            i_bit,
  output logic [GF_W-1:0] o_next_acc
);

  logic [GF_W-1:0] w_sq;

  assign w_sq       = gf64_sq(i_acc);
  assign o_next_acc = i_bit ? gf64_mul(w_sq, i_base) : w_sq;

endmodule

// File: rtl/gf64_pow_engine.sv
// Multi-lane GF(2^6) power engine: y = x^e via left-to-right square-and-multiply,
// one exponent bit per cycle, with valid/ready handshakes on both sides.
module gf64_pow_engine
  import gf64_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned EXP_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [GF_W*LANES-1:0] i_in_data,
  input  logic [EXP_W-1:0]      i_in_exp,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [GF_W*LANES-1:0] o_out_data,
  output logic                  o_busy
);

  localparam int unsigned KW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int unsigned DW = GF_W * LANES;

  state_e           r_state;
  state_e           w_state_next;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    r_base;
  logic [DW-1:0]    r_out_data;
  logic [DW-1:0]    w_next_acc;
  logic [EXP_W-1:0] r_exp;
  logic [KW-1:0]    r_k;
  logic             w_bit;

  assign w_bit = |(r_exp & (EXP_W'(1) << r_k));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gf64_lane_step u_step (
      .i_acc      (r_acc[lane_lsb(g) +: GF_W]),
      .i_base     (r_base[lane_lsb(g) +: GF_W]),
      .i_bit      (w_bit),
      .o_next_acc (w_next_acc[lane_lsb(g) +: GF_W])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_in_valid) w_state_next = StRun;
      StRun:   if (r_k == '0) w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_base     <= '0;
      r_exp      <= '0;
      r_k        <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_base <= i_in_data;
            r_exp  <= i_in_exp;
            r_k    <= KW'(EXP_W - 1);
            for (int unsigned i = 0; i < LANES; i++) begin
              r_acc[lane_lsb(i) +: GF_W] <= GF_W'(1);
            end
          end
        end
        StRun: begin
          r_acc <= w_next_acc;
          if (r_k == '0) r_out_data <= w_next_acc;
          else           r_k        <= r_k - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_busy      = (r_state != StIdle);
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_gf64_pow_engine.sv
// Scoreboard bench for gf64_pow_engine: expected words are queued when a request is
// driven and compared when the engine completes an output handshake.
module tb_gf64_pow_engine;

  localparam int unsigned LANES = 4;
  localparam int unsigned EXP_W = 6;
  localparam int unsigned DW    = 6 * LANES;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [EXP_W-1:0] in_exp = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             busy;

  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;
  logic [DW-1:0]  sb[$];

  gf64_pow_engine #(.LANES(LANES), .EXP_W(EXP_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_exp    (in_exp),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full carry-less product, then reduce from the top bit down.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] p;
    logic [11:0] poly;
    p = '0;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (12'(a) << i);
    for (int i = 10; i >= 6; i--) begin
      poly = 12'h043 << (i - 6);
      if (p[i]) p = p ^ poly;
    end
    return p[5:0];
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_lanes(input logic [DW-1:0] d, input int e);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[6*i +: 6] = ref_pow(d[6*i +: 6], e);
    return r;
  endfunction

  function automatic logic [5:0] ref_inv(input logic [5:0] x);
    logic [5:0] y;
    for (int i = 1; i < 64; i++) begin
      y = 6'(i);
      if (ref_mul(x, y) == 6'd1) return y;
    end
    return 6'd0;
  endfunction

  // Pops on the cycle before the handshake edge; inputs only change just after posedge.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      e = (sb.size() != 0) ? sb.pop_front() : ~out_data;
      check("out_data", 64'(out_data), 64'(e));
    end
  end

  // Drives a request, returns #1 after the accepting edge with in_valid still high.
  task automatic send(input logic [DW-1:0] d, input logic [5:0] e, input logic [DW-1:0] exp,
                      output int acc_cyc);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_exp   = e;
    sb.push_back(exp);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    acc_cyc = cyc;
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 64'(lat), 64'(EXP_W + 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int            t;
    int            prev;
    logic [DW-1:0] d;
    logic [DW-1:0] exp1;
    logic [5:0]    e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Basic x^5: lanes {0:2, 1:3, 2:0, 3:1} -> {32, 51, 0, 1}.
    send({6'd1, 6'd0, 6'd3, 6'd2}, 6'd5, {6'd1, 6'd0, 6'd51, 6'd32}, t);
    in_valid = 1'b0;
    measure_latency("lat_basic");
    drain();

    send({4{6'd2}}, 6'd62, {4{6'd33}}, t);
    send({4{6'd2}}, 6'd63, {4{6'd1}}, t);
    send({4{6'd2}}, 6'd6, {4{6'd3}}, t);
    in_valid = 1'b0;
    drain();

    // Inversion across the whole multiplicative group.
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < LANES; l++) d[6*l +: 6] = 6'(((4 * b + l) % 63) + 1);
      for (int l = 0; l < LANES; l++) exp1[6*l +: 6] = ref_inv(d[6*l +: 6]);
      send(d, 6'd62, exp1, t);
    end
    in_valid = 1'b0;
    drain();

    // x^0 = 1 for all x, including 0, with full latency.
    send({6'd17, 6'd63, 6'd2, 6'd0}, 6'd0, {4{6'd1}}, t);
    in_valid = 1'b0;
    measure_latency("lat_zero_exp");
    drain();

    // Backpressure in DONE with a second request waiting.
    out_ready = 1'b0;
    d    = {6'd63, 6'd40, 6'd9, 6'd5};
    exp1 = ref_lanes(d, 13);
    send(d, 6'd13, exp1, t);
    in_valid = 1'b0;
    measure_latency("lat_bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        d = {6'd7, 6'd11, 6'd0, 6'd44};
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = 6'd37;
        sb.push_back(ref_lanes(d, 37));
      end
      @(negedge clk);
      check("bp_hold", 64'(out_data), 64'(exp1));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_keep_data", 64'(out_data), 64'(exp1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_busy", 64'(busy), 64'd1);
    drain();

    // Reset on the third RUN cycle discards the in-flight result.
    in_valid = 1'b1;
    in_data  = {4{6'd3}};
    in_exp   = 6'd9;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_run_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_out_valid", 64'(out_valid), 64'd0);
    check("rr_out_data", 64'(out_data), 64'd0);
    check("rr_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send({4{6'd2}}, 6'd5, {4{6'd32}}, t);
    in_valid = 1'b0;
    measure_latency("lat_after_rst");
    drain();

    // Back-to-back stream with in_valid and out_ready held high.
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom);
      e = 6'($urandom_range(0, 63));
      send(d, e, ref_lanes(d, int'(e)), t);
      if (i > 0) check("issue_interval", 64'(t - prev), 64'(EXP_W + 2));
      prev = t;
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
